valid_skid_buffer: RTL and testbench

Two-entry register slice that cuts the forward valid/data path of a valid/ready stream: the egress valid and data come straight from flops, and ingress ready is also a flop. It pairs with the ready-path skid buffer to give a fully registered stream boundary at 1 word/cycle. It sits between a producer with late-arriving valid/data timing and any downstream consumer.

---
 rtl/skid_pkg.sv | 23 ++
 rtl/valid_skid_buffer_en_reg.sv | 21 ++
 rtl/valid_skid_buffer.sv | 101 ++++++++++
 tb/tb_valid_skid_buffer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/skid_pkg.sv
// Shared definitions for the valid-path and ready-path skid buffers.
package skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam logic [1:0] COUNT_EMPTY = 2'd0;
  localparam logic [1:0] COUNT_BUSY  = 2'd1;
  localparam logic [1:0] COUNT_FULL  = 2'd2;

  // Number of words held in a given occupancy state.
  function automatic logic [1:0] state_count(input skid_state_t s);
    case (s)
      BUSY:    state_count = COUNT_BUSY;
      FULL:    state_count = COUNT_FULL;
      default: state_count = COUNT_EMPTY;
    endcase
  endfunction

endpackage

// File: rtl/valid_skid_buffer_en_reg.sv
// Enable register: loads d when en is high, clears to zero on reset.
module en_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Storage flop with load enable and asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/valid_skid_buffer.sv
// Two-entry register slice: egress valid/data and ingress ready all come from flops.
module valid_skid_buffer
  import skid_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_valid_i,
  input  logic [WIDTH-1:0] i_data_i,
  output logic             i_ready_o,
  output logic             e_valid_o,
  output logic [WIDTH-1:0] e_data_o,
  input  logic             e_ready_i,
  output logic [1:0]       count_o
);

  skid_state_t      state_q;
  skid_state_t      state_d;
  logic             load_out;
  logic             load_skid;
  logic             out_from_skid;
  logic [WIDTH-1:0] out_d;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] skid_q;
  logic             i_fire;
  logic             e_fire;

  assign i_fire   = i_valid_i && i_ready_o;
  assign e_fire   = e_valid_o && e_ready_i;
  assign out_d    = out_from_skid ? skid_q : i_data_i;
  assign e_data_o = out_q;

  // Next-state decode and data-register load enables for each occupancy transition.
  always_comb begin
    state_d       = state_q;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (i_fire) begin
          state_d  = BUSY;
          load_out = 1'b1;
        end
      end
      BUSY: begin
        if (i_fire && e_fire) begin
          load_out = 1'b1;
        end else if (i_fire) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (e_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (e_fire) begin
          state_d       = BUSY;
          load_out      = 1'b1;
          out_from_skid = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State register plus status outputs decoded from the next state so they are pure flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= EMPTY;
      i_ready_o <= 1'b1;
      e_valid_o <= 1'b0;
      count_o   <= COUNT_EMPTY;
    end else begin
      state_q   <= state_d;
      i_ready_o <= (state_d != FULL);
      e_valid_o <= (state_d != EMPTY);
      count_o   <= state_count(state_d);
    end
  end

  en_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_out),
    .d     (out_d),
    .q     (out_q)
  );

  en_reg #(.WIDTH(WIDTH)) u_skid_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (load_skid),
    .d     (i_data_i),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_valid_skid_buffer.sv
// Self-checking bench: two widths driven in lockstep against a FIFO-queue reference model.
module tb_valid_skid_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_data;
  logic        e_ready;

  logic        i_ready8, e_valid8;
  logic [7:0]  e_data8;
  logic [1:0]  count8;
  logic        i_ready32, e_valid32;
  logic [31:0] e_data32;
  logic [1:0]  count32;

  int compares   = 0;
  int mismatches = 0;

  logic [31:0] mq[$];
  logic [31:0] olog[$];
  logic [31:0] pq[$];

  always #5 clk = ~clk;

  valid_skid_buffer #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid_i (i_valid),
    .i_data_i  (i_data[7:0]),
    .i_ready_o (i_ready8),
    .e_valid_o (e_valid8),
    .e_data_o  (e_data8),
    .e_ready_i (e_ready),
    .count_o   (count8)
  );

  valid_skid_buffer #(.WIDTH(32)) dut32 (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_valid_i (i_valid),
    .i_data_i  (i_data),
    .i_ready_o (i_ready32),
    .e_valid_o (e_valid32),
    .e_data_o  (e_data32),
    .e_ready_i (e_ready),
    .count_o   (count32)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compares++;
    assert (obs === exp)
    else begin
      mismatches++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare both DUTs against the queue model: ready while fewer than 2 held, valid while non-empty.
  task automatic checkOutput();
    chk("ready8",  32'(i_ready8),  32'(mq.size() < 2));
    chk("valid8",  32'(e_valid8),  32'(mq.size() > 0));
    chk("count8",  32'(count8),    32'(mq.size()));
    chk("ready32", 32'(i_ready32), 32'(mq.size() < 2));
    chk("valid32", 32'(e_valid32), 32'(mq.size() > 0));
    chk("count32", 32'(count32),   32'(mq.size()));
    if (mq.size() > 0) begin
      chk("data8",  32'(e_data8), {24'h0, mq[0][7:0]});
      chk("data32", e_data32,     mq[0]);
    end
  endtask

  // One clock: check outputs, then advance the model by the handshakes it predicts.
  task automatic applyStimulus();
    bit in_f, eg_f;
    checkOutput();
    in_f = i_valid && (mq.size() < 2);
    eg_f = e_ready && (mq.size() > 0);
    if (e_valid8 && e_ready) olog.push_back(32'(e_data8));
    @(posedge clk);
    if (eg_f) void'(mq.pop_front());
    if (in_f) mq.push_back(i_data);
    #1;
  endtask

  // Offer the head of pq for one cycle and drop it from pq if the model says it was taken.
  task automatic offerHead(input bit er);
    bit taken;
    i_valid = (pq.size() > 0);
    i_data  = (pq.size() > 0) ? pq[0] : 32'h0;
    e_ready = er;
    taken   = i_valid && (mq.size() < 2);
    applyStimulus();
    if (taken) void'(pq.pop_front());
  endtask

  initial begin
    int low_cycles;
    int words;
    bit saw_full;
    logic [31:0] exp_stall[4];
    logic [31:0] exp_long[3];

    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    e_ready = 1'b0;

    // Reset then idle.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",   32'(i_ready8), 32'd1);
    chk("rst_valid",   32'(e_valid8), 32'd0);
    chk("rst_data8",   32'(e_data8),  32'd0);
    chk("rst_count",   32'(count8),   32'd0);
    chk("rst_data32",  e_data32,      32'd0);
    rst_n = 1'b1;

    // Streaming 0x01..0x10 with egress always ready.
    for (int i = 1; i <= 16; i++) begin
      i_valid = 1'b1;
      i_data  = 32'(i);
      e_ready = 1'b1;
      chk("stream_ready", 32'(i_ready8), 32'd1);
      applyStimulus();
      chk("stream_count", 32'(count8), 32'd1);
      chk("stream_data",  32'(e_data8), 32'(i));
    end

    // Single-cycle stall while BUSY holding 0x10.
    olog.delete();
    pq = '{32'hA1, 32'hA2, 32'hA3};
    low_cycles = 0;
    saw_full   = 1'b0;
    for (int c = 0; c < 20 && (pq.size() > 0 || mq.size() > 0); c++) begin
      offerHead(c != 0);
      if (count8 == 2'd2) saw_full = 1'b1;
      if (!i_ready8) low_cycles++;
    end
    i_valid = 1'b0;
    chk("stall_full",      32'(saw_full),   32'd1);
    chk("stall_ready_low", 32'(low_cycles), 32'd1);
    chk("stall_nwords",    32'(olog.size()), 32'd4);
    exp_stall = '{32'h10, 32'hA1, 32'hA2, 32'hA3};
    for (int k = 0; k < 4; k++)
      if (k < olog.size()) chk("stall_order", olog[k], exp_stall[k]);

    // Long stall: ten cycles of backpressure with three words offered.
    olog.delete();
    pq = '{32'h55, 32'h66, 32'h77};
    for (int c = 0; c < 10; c++) begin
      offerHead(1'b0);
      chk("long_hold_data",  32'(e_data8),  32'h55);
      chk("long_hold_valid", 32'(e_valid8), 32'd1);
    end
    chk("long_left",  32'(pq.size()), 32'd1);
    chk("long_count", 32'(count8),    32'd2);
    for (int c = 0; c < 20 && (pq.size() > 0 || mq.size() > 0); c++) offerHead(1'b1);
    i_valid = 1'b0;
    chk("long_nwords", 32'(olog.size()), 32'd3);
    exp_long = '{32'h55, 32'h66, 32'h77};
    for (int k = 0; k < 3; k++)
      if (k < olog.size()) chk("long_order", olog[k], exp_long[k]);

    // Reset while FULL with 0xDE/0xAD held.
    pq = '{32'hDE, 32'hAD};
    offerHead(1'b0);
    offerHead(1'b0);
    i_valid = 1'b0;
    chk("mid_full", 32'(count8), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    mq.delete();
    chk("mid_ready",  32'(i_ready8),  32'd1);
    chk("mid_valid",  32'(e_valid8),  32'd0);
    chk("mid_data8",  32'(e_data8),   32'd0);
    chk("mid_count",  32'(count8),    32'd0);
    chk("mid_data32", e_data32,       32'd0);
    chk("mid_cnt32",  32'(count32),   32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    olog.delete();
    e_ready = 1'b1;
    repeat (4) applyStimulus();
    chk("mid_no_ghost", 32'(olog.size()), 32'd0);

    // Randomised valid/ready at 50% until 10k words accepted.
    words = 0;
    for (int c = 0; c < 60000 && words < 10000; c++) begin
      i_valid = 1'($urandom % 2);
      i_data  = $urandom;
      e_ready = 1'($urandom % 2);
      if (i_valid && mq.size() < 2) words++;
      applyStimulus();
    end
    chk("rand_words", 32'(words), 32'd10000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
    $finish;
  end

endmodule
